// File: rtl/vend_if.sv
// Vending machine coin/cancel inputs and status outputs.
//   master: drives coin_f/coin_h/coin_p/cancel and observes the status outputs.
//   slave : the vending FSM; samples the sensors and drives state, credit,
//           dispense, refund, refund_amt and coin_reject.
interface vend_if;
    logic       coin_f;       // farthing sensor (1 farthing), async level
    logic       coin_h;       // ha'penny sensor (2 farthings), async level
    logic       coin_p;       // penny sensor (4 farthings), async level
    logic       cancel;       // cancel button, async level
    logic [3:0] state;        // registered state code
    logic [1:0] credit;       // accumulated credit in farthings
    logic       dispense;     // item being vended
    logic       refund;       // credit being returned
    logic [1:0] refund_amt;   // farthings returned while refund is high
    logic       coin_reject;  // one-cycle pulse on a discarded event

    modport master (
        output coin_f, coin_h, coin_p, cancel,
        input  state, credit, dispense, refund, refund_amt, coin_reject
    );

    modport slave (
        input  coin_f, coin_h, coin_p, cancel,
        output state, credit, dispense, refund, refund_amt, coin_reject
    );
endinterface

// File: rtl/vend_fsm.sv
// Coin-operated vending FSM. Item price is one penny (4 farthings); coins of
// 1, 2 and 4 farthings are accepted, credit up to 3 farthings is accumulated,
// overpayment is vended with change encoded in the state code, and cancel
// refunds the accumulated credit. Vend and refund states are held for
// HOLD_CYCLES clocks before returning to zero credit.
//
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - vend_if slave: async coin/cancel sensors in, registered status out
module vend_fsm #(
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input logic   clk,
    input logic   reset_n,
    vend_if.slave bus
);

    localparam int unsigned       HoldW    = $clog2(HOLD_CYCLES);
    localparam logic [HoldW-1:0]  HoldLast = HoldW'(HOLD_CYCLES - 1);

    typedef enum logic [3:0] {
        StCredit0 = 4'd0,
        StCredit1 = 4'd1,
        StCredit2 = 4'd2,
        StCredit3 = 4'd3,
        StVend    = 4'd4,  // exact payment
        StRefund  = 4'd5,
        StVendF   = 4'd6,  // change: one farthing
        StVendH   = 4'd7,  // change: ha'penny
        StVendHf  = 4'd8   // change: ha'penny + farthing
    } state_e;

    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [1:0]       credit_q, credit_d;
    logic             dispense_q, dispense_d;
    logic             refund_q, refund_d;
    logic [1:0]       refund_amt_q, refund_amt_d;
    logic             coin_reject_q, coin_reject_d;

    // Bit order {cancel, penny, ha'penny, farthing}.
    logic [3:0] raw;
    logic [3:0] sync1_q, sync2_q, hist_q;
    logic [3:0] ev;
    logic [1:0] n_coins;
    logic [2:0] coin_val;
    logic [2:0] total;

    assign raw = {bus.cancel, bus.coin_p, bus.coin_h, bus.coin_f};

    // Synchroniser and history reset high so a level held across reset
    // release is not mistaken for a new event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 4'hf;
            sync2_q <= 4'hf;
            hist_q  <= 4'hf;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign ev      = sync2_q & ~hist_q;
    assign n_coins = {1'b0, ev[0]} + {1'b0, ev[1]} + {1'b0, ev[2]};
    // Coin bit positions already carry binary weights 1/2/4; only meaningful
    // when exactly one coin event is present.
    assign coin_val = ev[2:0];
    assign total    = {1'b0, state_q[1:0]} + coin_val;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StCredit0;
            hold_q        <= '0;
            credit_q      <= '0;
            dispense_q    <= 1'b0;
            refund_q      <= 1'b0;
            refund_amt_q  <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            credit_q      <= credit_d;
            dispense_q    <= dispense_d;
            refund_q      <= refund_d;
            refund_amt_q  <= refund_amt_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        hold_d        = '0;
        coin_reject_d = 1'b0;
        case (state_q)
            StCredit0, StCredit1, StCredit2, StCredit3: begin
                if (ev[3]) begin
                    // Cancel wins over coins; any coins alongside are dropped.
                    coin_reject_d = (n_coins != 2'd0);
                    if (state_q != StCredit0) begin
                        state_d = StRefund;
                    end
                end else if (n_coins > 2'd1) begin
                    coin_reject_d = 1'b1;
                end else if (n_coins == 2'd1) begin
                    case (total)
                        3'd4:    state_d = StVend;
                        3'd5:    state_d = StVendF;
                        3'd6:    state_d = StVendH;
                        3'd7:    state_d = StVendHf;
                        default: state_d = state_e'({1'b0, total});
                    endcase
                end
            end
            StVend, StRefund, StVendF, StVendH, StVendHf: begin
                coin_reject_d = (n_coins != 2'd0);
                if (hold_q == HoldLast) begin
                    state_d = StCredit0;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: state_d = StCredit0;  // unused codes recover to zero credit
        endcase
    end

    // Output logic: decoded from the next state so every output is registered
    // alongside the state code it belongs to.
    always_comb begin
        credit_d     = '0;
        dispense_d   = 1'b0;
        refund_d     = 1'b0;
        refund_amt_d = '0;
        case (state_d)
            StCredit0, StCredit1, StCredit2, StCredit3: begin
                credit_d = state_d[1:0];
            end
            StVend, StVendF, StVendH, StVendHf: begin
                dispense_d = 1'b1;
            end
            StRefund: begin
                refund_d = 1'b1;
                // Capture the prior credit on entry, hold it for the duration.
                refund_amt_d = (state_q == StRefund) ? refund_amt_q : state_q[1:0];
            end
            default: ;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.credit      = credit_q;
    assign bus.dispense    = dispense_q;
    assign bus.refund      = refund_q;
    assign bus.refund_amt  = refund_amt_q;
    assign bus.coin_reject = coin_reject_q;

endmodule

// File: tb/tb_vend_fsm.sv
// Bench for vend_fsm with HOLD_CYCLES=4: directed scenarios plus randomized
// coin/cancel/reset traffic checked cycle by cycle against a transaction-level
// model of the vending rules.
module tb_vend_fsm;

    localparam int HOLD  = 4;
    localparam int PRICE = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    vend_if vif ();

    vend_fsm #(.HOLD_CYCLES(HOLD)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (vif.slave)
    );

    always #5 clk = ~clk;

    logic [10:0] dut_vec;
    assign dut_vec = {vif.state, vif.credit, vif.dispense, vif.refund, vif.refund_amt,
                      vif.coin_reject};

    // ---------------- reference model ----------------
    int         m_mode;    // 0 accumulating credit, 1 vending, 2 refunding
    int         m_credit;
    int         m_change;
    int         m_amt;
    int         m_hold;    // cycles left in vend/refund
    bit         m_rej;
    logic [3:0] m_samp [3]; // input samples from the last three edges, newest first

    task automatic model_reset();
        m_mode = 0; m_credit = 0; m_change = 0; m_amt = 0; m_hold = 0; m_rej = 0;
        for (int i = 0; i < 3; i++) m_samp[i] = 4'hf;
    endtask

    task automatic model_step();
        logic [3:0] ev;
        int nc, v, t;
        // An input rising is acted on two edges after it is first seen high.
        ev = m_samp[1] & ~m_samp[2];
        m_samp[2] = m_samp[1];
        m_samp[1] = m_samp[0];
        m_samp[0] = {vif.cancel, vif.coin_p, vif.coin_h, vif.coin_f};
        nc = int'(ev[0]) + int'(ev[1]) + int'(ev[2]);
        v  = int'(ev[0]) * 1 + int'(ev[1]) * 2 + int'(ev[2]) * 4;
        m_rej = 0;
        if (m_mode == 0) begin
            if (ev[3]) begin
                if (nc > 0) m_rej = 1;
                if (m_credit > 0) begin
                    m_mode = 2; m_amt = m_credit; m_credit = 0; m_hold = HOLD;
                end
            end else if (nc > 1) begin
                m_rej = 1;
            end else if (nc == 1) begin
                t = m_credit + v;
                if (t < PRICE) m_credit = t;
                else begin
                    m_mode = 1; m_change = t - PRICE; m_credit = 0; m_hold = HOLD;
                end
            end
        end else begin
            if (nc > 0) m_rej = 1;
            m_hold--;
            if (m_hold == 0) begin
                m_mode = 0; m_amt = 0; m_change = 0;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    function automatic logic [10:0] exp_vec();
        logic [3:0] st;
        logic [1:0] cr, amt;
        st  = (m_mode == 2) ? 4'd5 :
              (m_mode == 1) ? ((m_change == 0) ? 4'd4 : 4'(m_change + 5)) : 4'(m_credit);
        cr  = (m_mode == 0) ? 2'(m_credit) : 2'd0;
        amt = (m_mode == 2) ? 2'(m_amt) : 2'd0;
        return {st, cr, 1'(m_mode == 1), 1'(m_mode == 2), amt, 1'(m_rej)};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] v);  // {cancel, p, h, f}
        {vif.cancel, vif.coin_p, vif.coin_h, vif.coin_f} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(4'b0000);
        reset_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (dut_vec !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", dut_vec, 11'd0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_exact_hh();
        logic [19:0] trace = '0;
        logic [3:0]  last = 4'd0;
        int          disp = 0;
        for (int i = 0; i < 14; i++) begin
            drive((i == 0 || i == 3) ? 4'b0010 : 4'b0000);
            tick();
            if (vif.state !== last) begin trace = {trace[15:0], vif.state}; last = vif.state; end
            if (vif.dispense === 1'b1) disp++;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL hh_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (trace !== 20'h00240) begin
            n_fail++; $display("FAIL hh_trace: got %h want %h", trace, 20'h00240);
        end
        n_cmp++;
        if (disp !== HOLD) begin
            n_fail++; $display("FAIL hh_dispense_cycles: got %0d want %0d", disp, HOLD);
        end
    endtask

    task automatic test_farthings_penny();
        logic [19:0] trace = '0;
        logic [3:0]  last = 4'd0;
        int          bad_credit = 0;
        for (int i = 0; i < 18; i++) begin
            drive((i == 0 || i == 2 || i == 4) ? 4'b0001 : (i == 6) ? 4'b0100 : 4'b0000);
            tick();
            if (vif.state !== last) begin trace = {trace[15:0], vif.state}; last = vif.state; end
            if (vif.dispense === 1'b1 && vif.credit !== 2'd0) bad_credit++;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL fffp_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (trace !== 20'h12380) begin
            n_fail++; $display("FAIL fffp_trace: got %h want %h", trace, 20'h12380);
        end
        n_cmp++;
        if (bad_credit !== 0) begin
            n_fail++; $display("FAIL fffp_credit_in_vend: got %0d want 0", bad_credit);
        end
    endtask

    task automatic test_cancel_refund();
        logic [19:0] trace = '0;
        logic [3:0]  last = 4'd0;
        int          amt2 = 0;
        for (int i = 0; i < 14; i++) begin
            drive((i == 0) ? 4'b0010 : (i == 2) ? 4'b1000 : 4'b0000);
            tick();
            if (vif.state !== last) begin trace = {trace[15:0], vif.state}; last = vif.state; end
            if (vif.refund === 1'b1 && vif.refund_amt === 2'd2) amt2++;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL refund_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (trace !== 20'h00250) begin
            n_fail++; $display("FAIL refund_trace: got %h want %h", trace, 20'h00250);
        end
        n_cmp++;
        if (amt2 !== HOLD || vif.refund_amt !== 2'd0) begin
            n_fail++;
            $display("FAIL refund_amt: got %0d cycles end %0d want %0d cycles end 0",
                     amt2, vif.refund_amt, HOLD);
        end
    endtask

    task automatic test_simul_coins();
        int rej = 0;
        int moved = 0;
        for (int i = 0; i < 8; i++) begin
            drive((i == 0) ? 4'b0011 : 4'b0000);
            tick();
            if (vif.coin_reject === 1'b1) rej++;
            if (vif.state !== 4'd0) moved++;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL simul_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (rej !== 1 || moved !== 0) begin
            n_fail++;
            $display("FAIL simul_reject: got rej=%0d moved=%0d want rej=1 moved=0", rej, moved);
        end
    endtask

    task automatic test_coin_during_vend();
        logic [19:0] trace = '0;
        logic [3:0]  last = 4'd0;
        int          rej = 0;
        int          v4 = 0;
        for (int i = 0; i < 12; i++) begin
            drive((i == 0) ? 4'b0100 : (i == 3) ? 4'b0001 : 4'b0000);
            tick();
            if (vif.state !== last) begin trace = {trace[15:0], vif.state}; last = vif.state; end
            if (vif.coin_reject === 1'b1) rej++;
            if (vif.state === 4'd4) v4++;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL busy_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (trace !== 20'h00040 || rej !== 1 || v4 !== HOLD || vif.credit !== 2'd0) begin
            n_fail++;
            $display("FAIL busy_coin: got trace=%h rej=%0d vend=%0d credit=%0d want 00040 1 %0d 0",
                     trace, rej, v4, vif.credit, HOLD);
        end
    endtask

    task automatic test_reset_held_input();
        logic [19:0] trace = '0;
        logic [3:0]  last = 4'd0;
        drive(4'b0100);
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (vif.state !== last) begin trace = {trace[15:0], vif.state}; last = vif.state; end
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL held_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (trace !== 20'h0) begin
            n_fail++; $display("FAIL held_no_event: got %h want %h", trace, 20'h0);
        end
        drive(4'b0000); tick(); tick();
        drive(4'b0100); tick();
        drive(4'b0000); tick(); tick();
        tick();
        n_cmp++;
        if (vif.state !== 4'd4 || vif.dispense !== 1'b1) begin
            n_fail++;
            $display("FAIL held_vend: got state=%0d disp=%b want 4 1", vif.state, vif.dispense);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (vif.state !== 4'd0 || vif.dispense !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL midvend_reset: got %h want %h", dut_vec, 11'd0);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec() || vif.dispense !== 1'b0) begin
                n_fail++;
                $display("FAIL after_abort cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] v = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                v[0] = ($urandom_range(0, 3) == 0);
                v[1] = ($urandom_range(0, 3) == 0);
                v[2] = ($urandom_range(0, 4) == 0);
                v[3] = ($urandom_range(0, 9) == 0);
            end
            drive(v);
            reset_n = ($urandom_range(0, 299) != 0);
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        reset_n = 1'b1;
        drive(4'b0000);
        repeat (HOLD + 4) tick();
    endtask

    initial begin
        drive(4'b0000);
        test_reset();
        test_exact_hh();
        test_farthings_penny();
        test_cancel_refund();
        test_simul_coins();
        test_coin_during_vend();
        test_reset_held_input();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_fsm.md
VEND_FSM -- requirements
Module: vend_fsm

Interface
REQ-001 Parameter HOLD_CYCLES, default 50000000, number of clock cycles a vend or refund state is held (minimum 2).
REQ-002 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 coin_f  input  1  farthing coin sensor, asynchronous level, value 1 farthing.
REQ-005 coin_h  input  1  ha'penny coin sensor, asynchronous level, value 2 farthings.
REQ-006 coin_p  input  1  penny coin sensor, asynchronous level, value 4 farthings.
REQ-007 cancel  input  1  cancel button, asynchronous level.
REQ-008 state  output  4  registered state code; this is the code consumed by the change-display decoder.
REQ-009 credit  output  2  accumulated credit in farthings (0-3).
REQ-010 dispense  output  1  high while the state code is 4, 6, 7 or 8.
REQ-011 refund  output  1  high while the state code is 5.
REQ-012 refund_amt  output  2  farthings being returned; valid while refund is high, 0 otherwise.
REQ-013 coin_reject  output  1  one-cycle pulse when a detected event is discarded.

Function
REQ-014 Each async input SHALL pass through a 2-flop synchroniser plus a history flop; an event is sync2 & ~hist.
REQ-015 An event SHALL update state on the 3rd rising clk edge after the input is first sampled high.
REQ-016 Item price SHALL be fixed at 4 farthings (1 penny).
REQ-017 State codes: 0-3 = CREDIT0-3 (credit = code); 4 = VEND exact; 5 = REFUND; 6 = VEND + 1 farthing change; 7 = VEND + ha'penny change; 8 = VEND + ha'penny + farthing change.
REQ-018 Codes 9-15 SHALL never be output; if reached they SHALL recover to 0 on the next edge.
REQ-019 In CREDITc, a single coin event of value v SHALL give t = c + v:
- t < 4 -> CREDITt;
- t = 4 -> 4;
- t = 5 -> 6;
- t = 6 -> 7;
- t = 7 -> 8.
REQ-020 credit SHALL be 0 in every non-CREDIT state.
REQ-021 A cancel event in CREDIT1-3 SHALL enter REFUND with refund_amt = prior credit.
REQ-022 A cancel event in CREDIT0 SHALL be ignored, with no coin_reject.
REQ-023 Two or more coin events in the same cycle SHALL all be discarded, with coin_reject pulsed and the state unchanged.
REQ-024 Cancel together with any coin event in CREDIT1-3 SHALL take REFUND, discard the coins and pulse coin_reject.
REQ-025 Cancel together with coin events in CREDIT0 SHALL discard all events and pulse coin_reject.
REQ-026 Coin events during a VEND or REFUND state SHALL be discarded with coin_reject pulsed.
REQ-027 Cancel events during a VEND or REFUND state SHALL be ignored.
REQ-028 On entry to a VEND or REFUND state, a hold counter (width clog2(HOLD_CYCLES)) SHALL load 0 and increment each cycle.
REQ-029 When the hold counter equals HOLD_CYCLES-1, the next state SHALL be CREDIT0, so the hold lasts exactly HOLD_CYCLES cycles.
REQ-030 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-031 Asserting reset_n low SHALL immediately force: state=0, credit=0, dispense=0, refund=0, refund_amt=0, coin_reject=0, hold counter=0.
REQ-032 Synchroniser and history flops SHALL reset to 1, so an input held high across reset release produces no event until it goes low and high again.
REQ-033 Reset asserted mid-vend or mid-refund SHALL abort it with no further dispense or refund, and the credit is lost.

Verification (HOLD_CYCLES=4)
REQ-034 coin_h, coin_h -> state 2 then 4; dispense high exactly 4 cycles; then state 0.
REQ-035 coin_f x3, then coin_p -> state 1, 2, 3, then 8; dispense high; credit 0.
REQ-036 coin_h, then cancel -> state 5, refund_amt=2 for 4 cycles; then state 0 with refund_amt=0.
REQ-037 coin_f and coin_h rising in the same cycle -> single coin_reject pulse; state stays 0.
REQ-038 coin_p, then coin_f during the vend -> coin_reject pulse; state 4 held for the full 4 cycles; then 0; credit 0.
REQ-039 coin_p held high through reset release, then reset_n low during state 4 -> no event at release; on the mid-vend reset, state 0 immediately and dispense 0.
